// File: rtl/fft_pkg.sv
// Shared constants, sample type and FSM encoding for the FFT burst unpacker.
package fft_pkg;

    localparam int BIT_DEPTH        = 18;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int BYTES_PER_SAMPLE = 8;
    localparam int FIELD_W          = 32;
    localparam int SAMPLE_W         = 2 * FIELD_W;

    typedef struct packed {
        logic signed [BIT_DEPTH-1:0] r;
        logic signed [BIT_DEPTH-1:0] i;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } unpack_state_e;

endpackage

// File: rtl/fft_lane_sat.sv
// Narrows one 32-bit two's complement field to BIT_DEPTH bits, clamping on overflow.
module fft_lane_sat
    import fft_pkg::*;
(
    input  logic [FIELD_W-1:0]          din,
    output logic signed [BIT_DEPTH-1:0] dout,
    output logic                        ovf
);
    localparam logic signed [BIT_DEPTH-1:0] SAT_MAX = {1'b0, {(BIT_DEPTH-1){1'b1}}};
    localparam logic signed [BIT_DEPTH-1:0] SAT_MIN = {1'b1, {(BIT_DEPTH-1){1'b0}}};

    // The value fits when every bit above the new sign bit copies it.
    always_comb begin
        ovf  = !((&din[FIELD_W-1:BIT_DEPTH-1]) || !(|din[FIELD_W-1:BIT_DEPTH-1]));
        dout = din[BIT_DEPTH-1:0];
        if (ovf) begin
            dout = din[FIELD_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/fft_burst_unpacker.sv
// Pops 512-bit burst words from an FWFT FIFO and presents one saturated complex sample per handshake.
module fft_burst_unpacker
    import fft_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LEN_W-1:0]            total_length,
    output logic                        busy,
    output logic                        done,
    input  logic [DATA_W-1:0]           fifoRdData,
    input  logic                        fifoEmpty,
    output logic                        fifoRdEn,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_DEPTH-1:0] out_r,
    output logic signed [BIT_DEPTH-1:0] out_i,
    output logic                        out_last,
    output logic                        sat_err,
    output unpack_state_e               fsm_state
);
    localparam int                LANE_W     = $clog2(SAMPLES_PER_WORD) + 1;
    localparam logic [LANE_W-1:0] FULL_LANES = LANE_W'(SAMPLES_PER_WORD);
    localparam logic [LEN_W-1:0]  STEP       = LEN_W'(BYTES_PER_SAMPLE);
    localparam int                LEN_SHIFT  = $clog2(BYTES_PER_SAMPLE);

    unpack_state_e     state;
    logic [DATA_W-1:0] word;
    logic [LEN_W-1:0]  remaining;
    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lanes;
    complex_t          sample;
    logic              sample_ovf;

    logic              handshake;
    logic [LANE_W-1:0] lane_next;
    logic [LEN_W-1:0]  rem_next;
    logic [LEN_W-1:0]  samples_left;
    logic [LANE_W-1:0] load_lanes;
    logic [DATA_W-1:0] src_word;
    logic [SAMPLE_W-1:0] slice;
    logic signed [BIT_DEPTH-1:0] sat_r;
    logic signed [BIT_DEPTH-1:0] sat_i;
    logic              ovf_r;
    logic              ovf_i;

    assign handshake    = out_valid & out_ready;
    assign lane_next    = lane + LANE_W'(1);
    assign rem_next     = remaining - STEP;
    assign samples_left = remaining >> LEN_SHIFT;
    assign load_lanes   = (samples_left >= LEN_W'(SAMPLES_PER_WORD)) ? FULL_LANES
                                                                      : samples_left[LANE_W-1:0];

    // The next sample comes from the FIFO head while loading, otherwise from the held word.
    assign src_word = (state == LOAD) ? fifoRdData
                                      : (word << (SAMPLE_W * int'(lane_next[LANE_W-2:0])));
    assign slice    = src_word[DATA_W-1 -: SAMPLE_W];

    fft_lane_sat u_sat_r (
        .din  (slice[SAMPLE_W-1:FIELD_W]),
        .dout (sat_r),
        .ovf  (ovf_r)
    );

    fft_lane_sat u_sat_i (
        .din  (slice[FIELD_W-1:0]),
        .dout (sat_i),
        .ovf  (ovf_i)
    );

    assign fifoRdEn  = (state == LOAD) && !fifoEmpty;
    assign busy      = (state != IDLE);
    assign out_r     = sample.r;
    assign out_i     = sample.i;
    assign fsm_state = state;

    // DONE stays until the done pulse has been shown, so a zero-length transfer
    // spends two cycles there while a normal transfer arrives with done already set.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            word       <= '0;
            remaining  <= '0;
            lane       <= '0;
            lanes      <= '0;
            sample     <= '0;
            sample_ovf <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            sat_err    <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= total_length & ~LEN_W'(7);
                        sat_err   <= 1'b0;
                        state     <= (total_length[LEN_W-1:3] == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (!fifoEmpty) begin
                        word       <= fifoRdData;
                        lane       <= '0;
                        lanes      <= load_lanes;
                        sample     <= {sat_r, sat_i};
                        sample_ovf <= ovf_r | ovf_i;
                        out_valid  <= 1'b1;
                        out_last   <= (remaining == STEP);
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        sat_err   <= sat_err | sample_ovf;
                        remaining <= rem_next;
                        lane      <= lane_next;
                        if (rem_next == '0) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else if (lane_next == lanes) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= LOAD;
                        end else begin
                            sample     <= {sat_r, sat_i};
                            sample_ovf <= ovf_r | ovf_i;
                            out_last   <= (rem_next == STEP);
                        end
                    end
                end
                DONE: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fft_burst_unpacker.md
# fft_burst_unpacker

Reads 512-bit burst words from an upstream FWFT FIFO and emits one complex FFT input sample per handshake. It is the consumer of the burst format our FFT testbench checks. Byte 0 of a burst sits at bits 511:504; each sample is 8 bytes, so there are 8 samples per word. The block sits between the DMA/receive FIFO and the FFT core input. It is started once per transfer with a byte length and signals completion.

## Interface
- DATA_W, 512, FIFO word width in bits; fixed at 512.
- BIT_DEPTH, 18, width of the signed real and imaginary output components.
- LEN_W, 16, width of the byte-length input.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored unless the state is IDLE.
- total_length  in  LEN_W  transfer length in bytes, sampled on start; bits [2:0] are ignored (length is rounded down to whole samples).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transfer completes.
- fifoRdData  in  DATA_W  head word of the FIFO; valid whenever fifoEmpty=0 (first-word-fall-through).
- fifoEmpty  in  1  FIFO has no data.
- fifoRdEn  out  1  pops the head word; asserted only when fifoEmpty=0.
- out_valid  out  1  a sample is presented.
- out_ready  in  1  the consumer accepts the sample.
- out_r, out_i  out  BIT_DEPTH  signed real and imaginary parts of the sample.
- out_last  out  1  marks the final sample of the transfer.
- sat_err  out  1  sticky flag: a field overflowed and was saturated; cleared on an accepted start.

## Operation
- State machine states: IDLE, LOAD, EMIT, DONE.
- **IDLE**
  - On start, latch remaining = total_length & ~7 and clear sat_err.
  - If remaining = 0, go to DONE. Otherwise go to LOAD.
- **LOAD**
  - Wait while fifoEmpty=1.
  - When fifoEmpty=0:
    - copy fifoRdData into the word register and assert fifoRdEn for exactly this cycle;
    - set lane = 0 and lanes = min(8, remaining/8);
    - go to EMIT.
- **EMIT**
  - Sample k is word[511-64k -: 64].
  - The real field is bits [63:32] of that slice and the imaginary field is bits [31:0]. Both are 32-bit two's complement.
  - Each field is converted to BIT_DEPTH:
    - if bits [31:17] are all equal, take bits [17:0] directly;
    - otherwise saturate to +131071 or −131072 according to bit 31, and set sat_err.
  - out_last = 1 when remaining = 8.
  - On handshake (out_valid & out_ready): remaining -= 8 and lane++. Then:
    - if remaining reaches 0, go to DONE;
    - else if lane reaches lanes, go to LOAD.
- Any unused lanes in the final word are discarded.
- **DONE**: done = 1 for one cycle, then go to IDLE.
- start while busy: ignored. total_length is not re-sampled.
- sat_err is updated only when a sample is accepted, so it is not set twice for one held sample.

## Timing
- Reset values:
  - state = IDLE;
  - busy, done, fifoRdEn, out_valid, out_last, sat_err all 0;
  - out_r = 0, out_i = 0.
- Reset in the middle of a transfer aborts it on the next edge. No further fifoRdEn is issued, and no done pulse is produced.
- Latency, with start in cycle 0 and the FIFO non-empty:
  - LOAD and fifoRdEn in cycle 1;
  - first out_valid in cycle 2;
  - done in the cycle after the last handshake.
- Throughput: one LOAD bubble per word, so 8 samples per 9 cycles at best.
- out_valid, out_r, out_i and out_last are registered. They hold stable while out_valid=1 and out_ready=0.
- fifoRdEn is never asserted while fifoEmpty=1, and never more than once per LOAD.
- total_length = 0: done pulses in cycle 2 with no fifoRdEn and no out_valid.

## Structure
- Package fft_pkg holds:
  - BIT_DEPTH = 18;
  - SAMPLES_PER_WORD = 8 and BYTES_PER_SAMPLE = 8;
  - typedef complex_t, a struct of signed [BIT_DEPTH-1:0] r and i;
  - the unpacker state enum.
- Sub-module fft_lane_sat: a combinational 32-to-BIT_DEPTH saturator with an overflow flag, instantiated once for the real field and once for the imaginary field.
- The top level holds the FSM, remaining/lane counters, word register and output registers.

## Test plan
- **Single full burst.** total_length = 64, the word holds r = k and i = −k for k = 0..7, out_ready held at 1:
  - required: 8 samples in order r = 0..7, i = 0..−7;
  - out_last on k = 7;
  - one fifoRdEn;
  - done one cycle after the last handshake.
- **Partial last word.** total_length = 0x58 (88 bytes) over two words:
  - required: 11 samples, exactly 2 fifoRdEn, out_last on the 11th;
  - the 5 unused lanes of word 2 are never output.
- **Backpressure and empty FIFO.**
  - Toggle out_ready randomly: outputs must stay stable while stalled, and no sample may be lost or duplicated.
  - Hold fifoEmpty = 1 for 5 cycles in LOAD: required state stays LOAD with fifoRdEn = 0.
- **Saturation.** Fields 0x0002_0000 and 0xFFFD_FFFF:
  - required: out_r = 131071 and out_i = −131072;
  - sat_err = 1 and stays 1 until the next start.
- **Corner cases.**
  - total_length = 0: done in cycle 2 with no fifoRdEn.
  - total_length = 7: treated the same as 0.
  - start pulsed during EMIT: ignored.
  - reset asserted during EMIT: all outputs are 0 on the next cycle and busy = 0.
